mem_line_responder: RTL and testbench

- Memory-side responder for the cache's line-wide memory interface: mem_read/mem_write, a 28-bit line address, 128-bit data and mem_ready.
- Holds a line store and answers each accepted request after a programmable latency, with a one-cycle mem_ready pulse.
- Used as the synthesizable slow-memory model under the instruction and data caches, and as the bring-up memory in the cache testbenches.

---
 rtl/mem_resp_pkg.sv | 13 +
 rtl/mem_line_array.sv | 30 +++
 rtl/mem_line_responder.sv | 86 ++++++++
 tb/tb_mem_line_responder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared widths, word slicing constants and FSM states for the line responder.
package mem_resp_pkg;
    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;
    localparam int WORD_W = 32;
    localparam int WORDS  = LINE_W / WORD_W;
    localparam int W0_LO  = 0 * WORD_W;
    localparam int W1_LO  = 1 * WORD_W;
    localparam int W2_LO  = 2 * WORD_W;
    localparam int W3_LO  = 3 * WORD_W;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: DEPTH x LINE_W line store with per-line valid bits cleared on reset.
module mem_line_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [LINE_W-1:0] rdata,
    output logic              rvalid
);
    logic [LINE_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    // Contents survive reset; only the valid bits are forgotten.
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk)
        if (clr) valid <= '0;
        else if (we) valid[waddr] <= 1'b1;

    assign rdata  = mem[raddr];
    assign rvalid = valid[raddr];
endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: slow line-wide memory model answering each request after LATENCY cycles.
module mem_line_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 256,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);
    localparam int IDX_W = $clog2(DEPTH);

    state_t            state, state_n;
    logic [7:0]        cnt;
    logic              op_wr;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] wbuf;
    logic [LINE_W-1:0] line;
    logic              line_valid;
    logic              req;
    logic              unused_addr;

    assign req         = mem_read | mem_write;
    assign unused_addr = ^mem_addr[ADDR_W-1:IDX_W];

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = req ? ((LATENCY == 1) ? RESP : BUSY) : IDLE;
            BUSY:    state_n = (cnt <= 8'd1) ? RESP : BUSY;
            RESP:    state_n = RELEASE;
            RELEASE: state_n = req ? RELEASE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            idx       <= '0;
            wbuf      <= '0;
            proto_err <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                op_wr <= mem_write;
                idx   <= mem_addr[IDX_W-1:0];
                wbuf  <= mem_wdata;
                cnt   <= 8'(LATENCY - 1);
                if (mem_read && mem_write) proto_err <= 1'b1;
            end
            if (state == BUSY) cnt <= cnt - 8'd1;
            if (state == RESP && op_wr && !(&wr_count)) wr_count <= wr_count + 1'b1;
            if (state == RESP && !op_wr && !(&rd_count)) rd_count <= rd_count + 1'b1;
        end
    end

    // The write lands on the edge that leaves RESP, so any later acceptance sees it.
    mem_line_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk    (clk),
        .clr    (proc_reset),
        .we     (state == RESP && op_wr),
        .waddr  (idx),
        .wdata  (wbuf),
        .raddr  (idx),
        .rdata  (line),
        .rvalid (line_valid)
    );

    assign mem_ready = (state == RESP);
    assign mem_rdata = (mem_ready && !op_wr && line_valid) ? line : '0;
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: scoreboard bench; stimulus queues expected responses, a monitor checks them.
module tb_mem_line_responder;
    localparam int LAT = 8;

    logic         clk = 0;
    logic         proc_reset = 1;
    logic         mem_read = 0;
    logic         mem_write = 0;
    logic [27:0]  mem_addr = '0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         proto_err;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    typedef struct {
        logic [127:0] rdata;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    localparam logic [127:0] D_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] D_B = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
    localparam logic [127:0] D_C = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;
    localparam logic [127:0] D_D = 128'h55555555_AAAAAAAA_33333333_CCCCCCCC;

    mem_line_responder #(.LATENCY(LAT), .DEPTH(256), .CNT_W(16)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .proto_err  (proto_err),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no response", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rdata", mem_rdata, e.rdata);
                check("ready_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] wd, input logic [127:0] exp, input int hold);
        bit seen = 0;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        q.push_back('{rdata: exp, cyc: cyc + LAT});
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = mem_ready;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready expected ready within 300 cycles");
        end
        repeat (hold) @(negedge clk);
        @(negedge clk);
        mem_read  = 0;
        mem_write = 0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", 128'(mem_ready), 128'(0));
        check("reset_rdata", mem_rdata, 128'(0));
        check("reset_proto", 128'(proto_err), 128'(0));
        check("reset_rd", 128'(rd_count), 128'(0));
        check("reset_wr", 128'(wr_count), 128'(0));
        proc_reset = 0;
        @(negedge clk);

        do_req(1, 0, 28'h0000005, '0, '0, 0);
        check("rd_cnt_1", 128'(rd_count), 128'(1));
        do_req(0, 1, 28'h0000005, D_A, '0, 0);
        do_req(1, 0, 28'h0000005, '0, D_A, 0);
        check("wr_cnt_1", 128'(wr_count), 128'(1));
        check("rd_cnt_2", 128'(rd_count), 128'(2));

        do_req(0, 1, 28'h0000105, D_B, '0, 0);
        do_req(1, 0, 28'h0000005, '0, D_B, 3);
        do_req(1, 0, 28'h0000005, '0, D_B, 0);
        check("rd_cnt_hold", 128'(rd_count), 128'(4));

        do_req(1, 1, 28'h0000002, 128'h1, '0, 0);
        check("proto_set", 128'(proto_err), 128'(1));
        check("wr_cnt_both", 128'(wr_count), 128'(3));
        do_req(1, 0, 28'h0000002, '0, 128'h1, 0);
        check("proto_sticky", 128'(proto_err), 128'(1));

        do_req(0, 1, 28'h0000003, D_C, '0, 0);
        do_req(1, 0, 28'h0000003, '0, D_C, 0);

        @(negedge clk);
        mem_write = 1;
        mem_addr  = 28'h0000003;
        mem_wdata = D_D;
        repeat (3) @(negedge clk);
        proc_reset = 1;
        mem_write  = 0;
        repeat (2) @(negedge clk);
        proc_reset = 0;
        repeat (LAT + 4) @(negedge clk);
        check("rst_rd_cnt", 128'(rd_count), 128'(0));
        check("rst_wr_cnt", 128'(wr_count), 128'(0));
        check("rst_proto", 128'(proto_err), 128'(0));
        do_req(1, 0, 28'h0000003, '0, '0, 0);
        do_req(1, 0, 28'h0000005, '0, '0, 0);
        check("rd_cnt_after_rst", 128'(rd_count), 128'(2));

        repeat (5) @(negedge clk);
        check("queue_empty", 128'(q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
